// File: rtl/alu_seq_p.sv
// Handshaked multi-cycle ALU: W-bit unsigned operands, 2W-bit result.
// ADD/SUB/logic ops finish in one EXEC cycle; MUL (shift-add) and DIV (restoring) take W cycles.
module alu_seq_p #(
    parameter int W  = 4,
    parameter int CW = $clog2(W + 1)
) (
    input  logic           clk,
    input  logic           en,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [2:0]     s,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [2*W-1:0] y,
    output logic           carry,
    output logic           zero,
    output logic           dz,
    output logic           out_valid,
    input  logic           out_ready
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_DIV = 3'd2, OP_MUL = 3'd3,
                           OP_AND = 3'd4, OP_OR  = 3'd5, OP_XOR = 3'd6;

    state_t           state_reg;
    logic [W-1:0]     a_reg, b_reg;
    logic [2:0]       s_reg;
    logic [CW-1:0]    cnt_reg;
    logic [2*W-1:0]   prod_reg, mcand_reg;
    logic [W-1:0]     rem_reg;
    logic [2*W-1:0]   y_reg;
    logic             carry_reg, zero_reg, dz_reg;

    logic [W:0]       sum_next;
    logic [W-1:0]     diff_next;
    logic [W-1:0]     and_next, or_next, xor_next;
    logic [2*W-1:0]   prod_next;
    logic [W:0]       trial;
    logic             take;
    logic [W-1:0]     rem_next, quot_next;
    logic             is_iter, iter_last;
    logic [2*W-1:0]   res_y;
    logic             res_carry, res_dz;

    assign sum_next  = {1'b0, a_reg} + {1'b0, b_reg};
    assign diff_next = a_reg - b_reg;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_logic
            assign and_next[gi] = a_reg[gi] & b_reg[gi];
            assign or_next[gi]  = a_reg[gi] | b_reg[gi];
            assign xor_next[gi] = a_reg[gi] ^ b_reg[gi];
        end
    endgenerate

    // MUL: b_reg shifts right, mcand_reg shifts left, one partial product per cycle.
    assign prod_next = prod_reg + (b_reg[0] ? mcand_reg : '0);

    // DIV: a_reg shifts dividend bits out of its MSB and quotient bits into its LSB.
    // With b==0 every trial succeeds, giving an all-ones quotient and remainder == a.
    assign trial     = {rem_reg, a_reg[W-1]};
    assign take      = trial >= {1'b0, b_reg};
    assign rem_next  = take ? (trial[W-1:0] - b_reg) : trial[W-1:0];
    assign quot_next = {a_reg[W-2:0], take};

    assign is_iter   = (s_reg == OP_DIV) || (s_reg == OP_MUL);
    assign iter_last = (cnt_reg == CW'(1));

    always_comb begin
        res_y     = '0;
        res_carry = 1'b0;
        res_dz    = 1'b0;
        case (s_reg)
            OP_ADD: begin
                res_y     = {{(W-1){1'b0}}, sum_next};
                res_carry = sum_next[W];
            end
            OP_SUB: begin
                res_y     = {{W{1'b0}}, diff_next};
                res_carry = (a_reg < b_reg);
            end
            OP_DIV: begin
                res_y  = {rem_next, quot_next};
                res_dz = (b_reg == '0);
            end
            OP_MUL: res_y = prod_next;
            OP_AND: res_y = {{W{1'b0}}, and_next};
            OP_OR:  res_y = {{W{1'b0}}, or_next};
            OP_XOR: res_y = {{W{1'b0}}, xor_next};
            default: res_y = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (en) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            cnt_reg   <= '0;
            prod_reg  <= '0;
            mcand_reg <= '0;
            rem_reg   <= '0;
            y_reg     <= '0;
            carry_reg <= 1'b0;
            zero_reg  <= 1'b0;
            dz_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        s_reg     <= s;
                        cnt_reg   <= CW'(W);
                        prod_reg  <= '0;
                        mcand_reg <= {{W{1'b0}}, a};
                        rem_reg   <= '0;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_iter) begin
                        cnt_reg <= cnt_reg - CW'(1);
                        if (s_reg == OP_MUL) begin
                            prod_reg  <= prod_next;
                            mcand_reg <= mcand_reg << 1;
                            b_reg     <= b_reg >> 1;
                        end else begin
                            rem_reg <= rem_next;
                            a_reg   <= quot_next;
                        end
                    end
                    if (!is_iter || iter_last) begin
                        y_reg     <= res_y;
                        carry_reg <= res_carry;
                        zero_reg  <= (res_y == '0);
                        dz_reg    <= res_dz;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign y         = y_reg;
    assign carry     = carry_reg;
    assign zero      = zero_reg;
    assign dz        = dz_reg;

endmodule

// File: tb/tb_alu_seq_p.sv
// Self-checking bench for alu_seq_p (W=4): directed table, random ops against an
// arithmetic reference model, backpressure and mid-operation reset sequences.
module tb_alu_seq_p;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           en = 1'b1;
    logic [W-1:0]   a = '0, b = '0;
    logic [2:0]     s = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2*W-1:0] y;
    logic           carry, zero, dz, out_valid;
    logic           out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_seq_p #(.W(W)) dut (
        .clk(clk), .en(en), .a(a), .b(b), .s(s), .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .carry(carry), .zero(zero), .dz(dz), .out_valid(out_valid), .out_ready(out_ready)
    );

    typedef struct {
        logic [2:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] y;
        logic           c;
        logic           z;
        logic           dz;
        int             lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model straight from the arithmetic definitions.
    task automatic model(input logic [2:0] op, input int av, input int bv,
                         output logic [2*W-1:0] ey, output logic ec, output logic ez,
                         output logic edz, output int elat);
        int m, r;
        m = 1 << W;
        ec = 0; edz = 0; elat = 1;
        case (op)
            3'd0: begin r = av + bv; ec = (r >= m); end
            3'd1: begin r = (av + m - bv) % m; ec = (av < bv); end
            3'd2: begin
                elat = W;
                if (bv == 0) begin r = av * m + (m - 1); edz = 1; end
                else r = (av % bv) * m + av / bv;
            end
            3'd3: begin elat = W; r = av * bv; end
            3'd4: r = av & bv;
            3'd5: r = av | bv;
            3'd6: r = av ^ bv;
            default: r = 0;
        endcase
        ey = r[2*W-1:0];
        ez = (ey == '0);
    endtask

    // Entry/exit point of every task: 1 time unit after a rising edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        chk("in_ready_before_issue", 64'(in_ready), 64'd1);
        s = op; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            chk("in_ready_busy", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_after_consume", 64'(out_valid), 64'd0);
        chk("in_ready_after_consume", 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [2*W-1:0] ey, input logic ec, input logic ez,
                          input logic edz, input int elat);
        int lat;
        issue(op, av, bv);
        wait_result(lat);
        $display("op=%0d a=%h b=%h -> y=%h carry=%b zero=%b dz=%b lat=%0d", op, av, bv, y, carry, zero, dz, lat);
        chk("latency", 64'(lat), 64'(elat));
        chk("y", 64'(y), 64'(ey));
        chk("carry", 64'(carry), 64'(ec));
        chk("zero", 64'(zero), 64'(ez));
        chk("dz", 64'(dz), 64'(edz));
        consume();
    endtask

    initial begin
        logic [2*W-1:0] ey;
        logic           ec, ez, edz;
        int             elat, lat;
        logic [2:0]     rop;
        logic [W-1:0]   ra, rb;

        vecs[0] = '{3'd0, 4'hF, 4'h1, 8'h10, 1'b1, 1'b0, 1'b0, 1};
        vecs[1] = '{3'd1, 4'h3, 4'h5, 8'h0E, 1'b1, 1'b0, 1'b0, 1};
        vecs[2] = '{3'd1, 4'h5, 4'h5, 8'h00, 1'b0, 1'b1, 1'b0, 1};
        vecs[3] = '{3'd3, 4'hF, 4'hF, 8'hE1, 1'b0, 1'b0, 1'b0, W};
        vecs[4] = '{3'd2, 4'hD, 4'h4, 8'h13, 1'b0, 1'b0, 1'b0, W};
        vecs[5] = '{3'd2, 4'h9, 4'h0, 8'h9F, 1'b0, 1'b0, 1'b1, W};
        vecs[6] = '{3'd7, 4'h9, 4'h3, 8'h00, 1'b0, 1'b1, 1'b0, 1};
        vecs[7] = '{3'd5, 4'hA, 4'h5, 8'h0F, 1'b0, 1'b0, 1'b0, 1};
        vecs[8] = '{3'd6, 4'hC, 4'hA, 8'h06, 1'b0, 1'b0, 1'b0, 1};
        vecs[9] = '{3'd0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        en = 1'b0;
        chk("reset_y", 64'(y), 64'd0);
        chk("reset_flags", 64'({carry, zero, dz}), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].c, vecs[i].z, vecs[i].dz, vecs[i].lat);

        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = W'($urandom);
            rb  = (i % 10 == 3) ? '0 : W'($urandom);
            model(rop, int'(ra), int'(rb), ey, ec, ez, edz, elat);
            run_op(rop, ra, rb, ey, ec, ez, edz, elat);
        end

        // Backpressure: result held while a new op waits on the input side.
        issue(3'd4, 4'hA, 4'h6);
        wait_result(lat);
        $display("op=4 a=a b=6 -> y=%h held under backpressure", y);
        s = 3'd0; a = 4'h3; b = 4'h4; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_y", 64'(y), 64'h02);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_idle_in_ready", 64'(in_ready), 64'd1);
        chk("bp_idle_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_pending_accepted", 64'(in_ready), 64'd0);
        wait_result(lat);
        $display("op=0 a=3 b=4 -> y=%h carry=%b lat=%0d", y, carry, lat);
        chk("bp_pending_latency", 64'(lat), 64'd1);
        chk("bp_pending_y", 64'(y), 64'h07);
        consume();

        // Reset during the second DIV iteration, with a nonzero prior result in y.
        run_op(3'd3, 4'h7, 4'h3, 8'h15, 1'b0, 1'b0, 1'b0, W);
        issue(3'd2, 4'hD, 4'h4);
        @(posedge clk); #1;
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        $display("reset mid-DIV -> y=%h carry=%b zero=%b dz=%b", y, carry, zero, dz);
        chk("rst_mid_y", 64'(y), 64'd0);
        chk("rst_mid_flags", 64'({carry, zero, dz}), 64'd0);
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        run_op(3'd0, 4'h2, 4'h2, 8'h04, 1'b0, 1'b0, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
